// File: rtl/sump_pkg.sv
// Shared opcodes, parser states and framing constants for the SUMP command decoder.
package sump_pkg;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_META      = 8'h02;
  localparam logic [7:0] OP_ID        = 8'h04;
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_CNT       = 8'h81;
  localparam logic [7:0] OP_TRIG_LVL  = 8'hC0;
  localparam logic [7:0] OP_TRIG_EDGE = 8'hC1;

  localparam int LONG_ARG_BYTES = 4;

  typedef enum logic {
    IDLE,
    ARGS
  } state_t;

endpackage

// File: rtl/sump_byte_timer.sv
// Restartable inter-byte counter; saturates at its terminal count instead of wrapping.
module sump_byte_timer #(
  parameter int BYTE_TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (BYTE_TIMEOUT_CYCLES > 2) ? $clog2(BYTE_TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTE_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/sump_cmd_decoder.sv
// SUMP byte-stream parser: executes short commands, collects long-command arguments
// into the capture configuration registers, and resynchronises on inter-byte timeout.
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int SAMPLE_WIDTH        = 8,
  parameter int BYTE_TIMEOUT_CYCLES = 100000
) (
  input  logic                    system_clock,
  input  logic                    ext_reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    busy,
  output logic                    soft_reset_pulse,
  output logic                    arm_pulse,
  output logic                    meta_req_pulse,
  output logic                    id_req_pulse,
  output logic [23:0]             divider,
  output logic [15:0]             read_count,
  output logic [15:0]             delay_count,
  output logic [SAMPLE_WIDTH-1:0] trig_level_mask,
  output logic [SAMPLE_WIDTH-1:0] trig_level_value,
  output logic [SAMPLE_WIDTH-1:0] trig_fall_mask,
  output logic [SAMPLE_WIDTH-1:0] trig_rise_mask,
  output logic                    cfg_update_pulse,
  output logic                    cmd_timeout_pulse
);

  localparam logic [1:0] LAST_ARG = 2'(LONG_ARG_BYTES - 1);

  state_t                  r_state, w_state_nxt;
  logic [7:0]              r_opcode, w_opcode_nxt;
  logic                    r_busy, w_busy_nxt;
  logic [1:0]              r_arg_cnt, w_arg_cnt_nxt;
  logic [7:0]              r_b1, r_b2, r_b3, w_b1_nxt, w_b2_nxt, w_b3_nxt;
  logic [23:0]             r_divider, w_divider_nxt;
  logic [15:0]             r_read_count, w_read_count_nxt;
  logic [15:0]             r_delay_count, w_delay_count_nxt;
  logic [SAMPLE_WIDTH-1:0] r_lvl_mask, w_lvl_mask_nxt;
  logic [SAMPLE_WIDTH-1:0] r_lvl_value, w_lvl_value_nxt;
  logic [SAMPLE_WIDTH-1:0] r_fall_mask, w_fall_mask_nxt;
  logic [SAMPLE_WIDTH-1:0] r_rise_mask, w_rise_mask_nxt;
  logic                    r_soft, r_arm, r_meta, r_id, r_cfg, r_tmo;
  logic                    w_soft_nxt, w_arm_nxt, w_meta_nxt, w_id_nxt, w_cfg_nxt, w_tmo_nxt;
  logic                    w_expire;

  // Timer runs only while waiting for an argument byte; any byte or IDLE restarts it.
  sump_byte_timer #(
    .BYTE_TIMEOUT_CYCLES(BYTE_TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk   (system_clock),
    .i_rst_n (ext_reset_n),
    .i_clear ((r_state == IDLE) || rx_valid),
    .i_enable((r_state == ARGS) && !rx_valid),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_opcode_nxt      = r_opcode;
    w_busy_nxt        = r_busy;
    w_arg_cnt_nxt     = r_arg_cnt;
    w_b1_nxt          = r_b1;
    w_b2_nxt          = r_b2;
    w_b3_nxt          = r_b3;
    w_divider_nxt     = r_divider;
    w_read_count_nxt  = r_read_count;
    w_delay_count_nxt = r_delay_count;
    w_lvl_mask_nxt    = r_lvl_mask;
    w_lvl_value_nxt   = r_lvl_value;
    w_fall_mask_nxt   = r_fall_mask;
    w_rise_mask_nxt   = r_rise_mask;
    w_soft_nxt        = 1'b0;
    w_arm_nxt         = 1'b0;
    w_meta_nxt        = 1'b0;
    w_id_nxt          = 1'b0;
    w_cfg_nxt         = 1'b0;
    w_tmo_nxt         = 1'b0;

    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[7]) begin
            w_state_nxt   = ARGS;
            w_opcode_nxt  = rx_data;
            w_busy_nxt    = busy;
            w_arg_cnt_nxt = '0;
          end else begin
            case (rx_data)
              OP_RESET: w_soft_nxt = 1'b1;
              OP_ARM:   w_arm_nxt  = !busy;
              OP_META:  w_meta_nxt = !busy;
              OP_ID:    w_id_nxt   = !busy;
              default:  ;
            endcase
          end
        end
      end
      ARGS: begin
        if (rx_valid) begin
          if (r_arg_cnt == LAST_ARG) begin
            // The fourth byte is used straight off the bus, saving a fourth argument register.
            w_state_nxt = IDLE;
            if (!r_busy) begin
              case (r_opcode)
                OP_DIV: begin
                  w_divider_nxt = {r_b2, r_b3, rx_data};
                  w_cfg_nxt     = 1'b1;
                end
                OP_CNT: begin
                  w_read_count_nxt  = {r_b1, r_b2};
                  w_delay_count_nxt = {r_b3, rx_data};
                  w_cfg_nxt         = 1'b1;
                end
                OP_TRIG_LVL: begin
                  w_lvl_value_nxt = r_b3[SAMPLE_WIDTH-1:0];
                  w_lvl_mask_nxt  = rx_data[SAMPLE_WIDTH-1:0];
                  w_cfg_nxt       = 1'b1;
                end
                OP_TRIG_EDGE: begin
                  w_fall_mask_nxt = r_b3[SAMPLE_WIDTH-1:0];
                  w_rise_mask_nxt = rx_data[SAMPLE_WIDTH-1:0];
                  w_cfg_nxt       = 1'b1;
                end
                default: ;
              endcase
            end
          end else begin
            w_arg_cnt_nxt = r_arg_cnt + 2'd1;
            case (r_arg_cnt)
              2'd0:    w_b1_nxt = rx_data;
              2'd1:    w_b2_nxt = rx_data;
              default: w_b3_nxt = rx_data;
            endcase
          end
        end else if (w_expire) begin
          w_state_nxt = IDLE;
          w_tmo_nxt   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      r_state       <= IDLE;
      r_opcode      <= '0;
      r_busy        <= 1'b0;
      r_arg_cnt     <= '0;
      r_b1          <= '0;
      r_b2          <= '0;
      r_b3          <= '0;
      r_divider     <= '0;
      r_read_count  <= '0;
      r_delay_count <= '0;
      r_lvl_mask    <= '0;
      r_lvl_value   <= '0;
      r_fall_mask   <= '0;
      r_rise_mask   <= '0;
      r_soft        <= 1'b0;
      r_arm         <= 1'b0;
      r_meta        <= 1'b0;
      r_id          <= 1'b0;
      r_cfg         <= 1'b0;
      r_tmo         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_opcode      <= w_opcode_nxt;
      r_busy        <= w_busy_nxt;
      r_arg_cnt     <= w_arg_cnt_nxt;
      r_b1          <= w_b1_nxt;
      r_b2          <= w_b2_nxt;
      r_b3          <= w_b3_nxt;
      r_divider     <= w_divider_nxt;
      r_read_count  <= w_read_count_nxt;
      r_delay_count <= w_delay_count_nxt;
      r_lvl_mask    <= w_lvl_mask_nxt;
      r_lvl_value   <= w_lvl_value_nxt;
      r_fall_mask   <= w_fall_mask_nxt;
      r_rise_mask   <= w_rise_mask_nxt;
      r_soft        <= w_soft_nxt;
      r_arm         <= w_arm_nxt;
      r_meta        <= w_meta_nxt;
      r_id          <= w_id_nxt;
      r_cfg         <= w_cfg_nxt;
      r_tmo         <= w_tmo_nxt;
    end
  end

  assign soft_reset_pulse  = r_soft;
  assign arm_pulse         = r_arm;
  assign meta_req_pulse    = r_meta;
  assign id_req_pulse      = r_id;
  assign cfg_update_pulse  = r_cfg;
  assign cmd_timeout_pulse = r_tmo;
  assign divider           = r_divider;
  assign read_count        = r_read_count;
  assign delay_count       = r_delay_count;
  assign trig_level_mask   = r_lvl_mask;
  assign trig_level_value  = r_lvl_value;
  assign trig_fall_mask    = r_fall_mask;
  assign trig_rise_mask    = r_rise_mask;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed bench for sump_cmd_decoder: bytes are driven on the falling edge and
// outputs are observed on the following falling edge.
module tb_sump_cmd_decoder;

  localparam int SW  = 8;
  localparam int TMO = 20;

  logic          system_clock = 1'b0;
  logic          ext_reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          busy;
  logic          soft_reset_pulse, arm_pulse, meta_req_pulse, id_req_pulse;
  logic [23:0]   divider;
  logic [15:0]   read_count, delay_count;
  logic [SW-1:0] trig_level_mask, trig_level_value, trig_fall_mask, trig_rise_mask;
  logic          cfg_update_pulse, cmd_timeout_pulse;

  int errors = 0;
  int checks = 0;
  int n_cfg = 0, n_tmo = 0, n_arm = 0, n_meta = 0, n_id = 0;

  sump_cmd_decoder #(
    .SAMPLE_WIDTH(SW),
    .BYTE_TIMEOUT_CYCLES(TMO)
  ) dut (
    .system_clock     (system_clock),
    .ext_reset_n      (ext_reset_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .busy             (busy),
    .soft_reset_pulse (soft_reset_pulse),
    .arm_pulse        (arm_pulse),
    .meta_req_pulse   (meta_req_pulse),
    .id_req_pulse     (id_req_pulse),
    .divider          (divider),
    .read_count       (read_count),
    .delay_count      (delay_count),
    .trig_level_mask  (trig_level_mask),
    .trig_level_value (trig_level_value),
    .trig_fall_mask   (trig_fall_mask),
    .trig_rise_mask   (trig_rise_mask),
    .cfg_update_pulse (cfg_update_pulse),
    .cmd_timeout_pulse(cmd_timeout_pulse)
  );

  initial forever #5 system_clock = ~system_clock;

  // Pulse tallies, taken on the rising edge so they never race the falling-edge checks.
  always @(posedge system_clock) begin
    if (ext_reset_n) begin
      n_cfg  = n_cfg  + int'(cfg_update_pulse);
      n_tmo  = n_tmo  + int'(cmd_timeout_pulse);
      n_arm  = n_arm  + int'(arm_pulse);
      n_meta = n_meta + int'(meta_req_pulse);
      n_id   = n_id   + int'(id_req_pulse);
    end
  end

  // Called at a falling edge; presents a byte for one cycle and returns at the next falling edge.
  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge system_clock);
  endtask

  task automatic gap();
    rx_valid = 1'b0;
    @(negedge system_clock);
  endtask

  task automatic test_reset();
    ext_reset_n = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    busy        = 1'b0;
    #1;
    checks++;
    if ({soft_reset_pulse, arm_pulse, meta_req_pulse, id_req_pulse, cfg_update_pulse,
         cmd_timeout_pulse, divider, read_count, delay_count, trig_level_mask,
         trig_level_value, trig_fall_mask, trig_rise_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got div=%h rc=%h dc=%h expected all zero", divider, read_count, delay_count);
    end
    repeat (2) @(negedge system_clock);
    ext_reset_n = 1'b1;
    repeat (2) @(negedge system_clock);
    checks++;
    if ({soft_reset_pulse, arm_pulse, meta_req_pulse, id_req_pulse, cfg_update_pulse,
         cmd_timeout_pulse, divider, read_count} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got div=%h rc=%h expected zero", divider, read_count);
    end
  endtask

  task automatic test_divider();
    int c0;
    c0   = n_cfg;
    busy = 1'b0;
    put(8'h80); put(8'h00); put(8'h98); put(8'h96);
    checks++;
    if ({divider, cfg_update_pulse} !== 25'h0) begin
      errors++;
      $display("FAIL div_early: got div=%h cfg=%b expected 000000/0", divider, cfg_update_pulse);
    end
    put(8'h7F);
    checks++;
    if (divider !== 24'h98967F) begin
      errors++;
      $display("FAIL div_value: got %h expected 98967f", divider);
    end
    checks++;
    if (cfg_update_pulse !== 1'b1) begin
      errors++;
      $display("FAIL div_cfg_pulse: got %b expected 1", cfg_update_pulse);
    end
    checks++;
    if ({read_count, delay_count, trig_level_mask, trig_level_value, trig_fall_mask, trig_rise_mask} !== '0) begin
      errors++;
      $display("FAIL div_others: got rc=%h dc=%h rise=%h expected zero", read_count, delay_count, trig_rise_mask);
    end
    gap();
    checks++;
    if (cfg_update_pulse !== 1'b0) begin
      errors++;
      $display("FAIL div_cfg_width: got %b expected 0", cfg_update_pulse);
    end
    gap();
    checks++;
    if (n_cfg - c0 !== 1) begin
      errors++;
      $display("FAIL div_cfg_count: got %0d expected 1", n_cfg - c0);
    end
  endtask

  task automatic test_cnt_trig();
    int c0;
    c0 = n_cfg;
    put(8'h81); put(8'h00); put(8'h03); put(8'h00); put(8'h03);
    gap();
    put(8'hC1); put(8'h00); put(8'h00); put(8'h00); put(8'h01);
    gap(); gap();
    checks++;
    if ({read_count, delay_count} !== 32'h0003_0003) begin
      errors++;
      $display("FAIL cnt_values: got rc=%h dc=%h expected 0003/0003", read_count, delay_count);
    end
    checks++;
    if ({trig_fall_mask, trig_rise_mask} !== 16'h0001) begin
      errors++;
      $display("FAIL edge_masks: got fall=%h rise=%h expected 00/01", trig_fall_mask, trig_rise_mask);
    end
    checks++;
    if (n_cfg - c0 !== 2) begin
      errors++;
      $display("FAIL cnt_edge_cfg_count: got %0d expected 2", n_cfg - c0);
    end
    checks++;
    if (divider !== 24'h98967F) begin
      errors++;
      $display("FAIL cnt_div_kept: got %h expected 98967f", divider);
    end
    put(8'hC0); put(8'h11); put(8'h22); put(8'hA5); put(8'h3C);
    gap();
    checks++;
    if ({trig_level_value, trig_level_mask, trig_rise_mask} !== 24'hA53C01) begin
      errors++;
      $display("FAIL level_trig: got val=%h mask=%h rise=%h expected a5/3c/01",
               trig_level_value, trig_level_mask, trig_rise_mask);
    end
  endtask

  task automatic test_short();
    logic [7:0] ops  [5] = '{8'h01, 8'h02, 8'h04, 8'h03, 8'h7F};
    logic [2:0] expv [5] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000};
    int a0, m0, i0;
    busy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(ops[k]);
      checks++;
      if ({arm_pulse, meta_req_pulse, id_req_pulse, soft_reset_pulse} !== {expv[k], 1'b0}) begin
        errors++;
        $display("FAIL short_%h: got a/m/i/s=%b%b%b%b expected %b0", ops[k],
                 arm_pulse, meta_req_pulse, id_req_pulse, soft_reset_pulse, expv[k]);
      end
      gap();
      checks++;
      if ({arm_pulse, meta_req_pulse, id_req_pulse} !== 3'b000) begin
        errors++;
        $display("FAIL short_width_%h: got a/m/i=%b%b%b expected 000", ops[k],
                 arm_pulse, meta_req_pulse, id_req_pulse);
      end
    end
    a0 = n_arm; m0 = n_meta; i0 = n_id;
    busy = 1'b1;
    put(8'h01); gap(); put(8'h02); gap(); put(8'h04); gap(); gap();
    checks++;
    if ((n_arm - a0) + (n_meta - m0) + (n_id - i0) !== 0) begin
      errors++;
      $display("FAIL short_busy_gated: got %0d pulses expected 0",
               (n_arm - a0) + (n_meta - m0) + (n_id - i0));
    end
    put(8'h00);
    checks++;
    if (soft_reset_pulse !== 1'b1) begin
      errors++;
      $display("FAIL soft_reset_busy: got %b expected 1", soft_reset_pulse);
    end
    checks++;
    if ({divider, read_count} !== 40'h98967F_0003) begin
      errors++;
      $display("FAIL soft_reset_keeps_cfg: got div=%h rc=%h expected 98967f/0003", divider, read_count);
    end
    gap();
    checks++;
    if (soft_reset_pulse !== 1'b0) begin
      errors++;
      $display("FAIL soft_reset_width: got %b expected 0", soft_reset_pulse);
    end
    busy = 1'b0;
  endtask

  task automatic test_busy_long();
    int c0;
    c0   = n_cfg;
    busy = 1'b1;
    put(8'h80); put(8'h00); put(8'h00); put(8'h01); put(8'hF3);
    checks++;
    if ({divider, cfg_update_pulse} !== {24'h98967F, 1'b0}) begin
      errors++;
      $display("FAIL busy_long_suppressed: got div=%h cfg=%b expected 98967f/0", divider, cfg_update_pulse);
    end
    gap();
    busy = 1'b0;
    put(8'h01);
    checks++;
    if (arm_pulse !== 1'b1) begin
      errors++;
      $display("FAIL busy_long_then_arm: got %b expected 1", arm_pulse);
    end
    gap(); gap();
    checks++;
    if (n_cfg - c0 !== 0) begin
      errors++;
      $display("FAIL busy_long_cfg_count: got %0d expected 0", n_cfg - c0);
    end
    // busy is only sampled with the opcode, so rising mid-command must not block the write
    put(8'h80); busy = 1'b1; put(8'h00); put(8'h00); put(8'h00); put(8'h42);
    checks++;
    if ({divider, cfg_update_pulse} !== {24'h000042, 1'b1}) begin
      errors++;
      $display("FAIL busy_sample_at_opcode: got div=%h cfg=%b expected 000042/1", divider, cfg_update_pulse);
    end
    gap();
    busy = 1'b0;
  endtask

  task automatic test_timeout();
    int t0;
    t0 = n_tmo;
    put(8'h81); put(8'h12); put(8'h34);
    repeat (TMO - 1) gap();
    checks++;
    if (cmd_timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b expected 0", cmd_timeout_pulse);
    end
    gap();
    checks++;
    if (cmd_timeout_pulse !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: got %b expected 1", cmd_timeout_pulse);
    end
    gap();
    checks++;
    if (n_tmo - t0 !== 1) begin
      errors++;
      $display("FAIL timeout_count: got %0d expected 1", n_tmo - t0);
    end
    checks++;
    if (read_count !== 16'h0003) begin
      errors++;
      $display("FAIL timeout_rc_kept: got %h expected 0003", read_count);
    end
    put(8'h00);
    checks++;
    if (soft_reset_pulse !== 1'b1) begin
      errors++;
      $display("FAIL timeout_resync: got %b expected 1", soft_reset_pulse);
    end
    gap();
  endtask

  task automatic test_timeout_edge();
    int t0;
    t0 = n_tmo;
    put(8'h81); put(8'h12); put(8'h34);
    repeat (TMO - 1) gap();
    put(8'h56);
    put(8'h78);
    checks++;
    if ({read_count, delay_count, cfg_update_pulse} !== {32'h1234_5678, 1'b1}) begin
      errors++;
      $display("FAIL expiry_byte_wins: got rc=%h dc=%h cfg=%b expected 1234/5678/1",
               read_count, delay_count, cfg_update_pulse);
    end
    gap(); gap();
    checks++;
    if (n_tmo - t0 !== 0) begin
      errors++;
      $display("FAIL expiry_no_timeout: got %0d expected 0", n_tmo - t0);
    end
  endtask

  task automatic test_unknown_b2b();
    int c0;
    c0 = n_cfg;
    put(8'h9A); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    checks++;
    if (cfg_update_pulse !== 1'b0) begin
      errors++;
      $display("FAIL unknown_no_cfg: got %b expected 0", cfg_update_pulse);
    end
    put(8'h01);
    checks++;
    if (arm_pulse !== 1'b1) begin
      errors++;
      $display("FAIL unknown_then_arm: got %b expected 1", arm_pulse);
    end
    put(8'h80); put(8'h00); put(8'h00); put(8'h00); put(8'h07);
    checks++;
    if ({divider, cfg_update_pulse} !== {24'h000007, 1'b1}) begin
      errors++;
      $display("FAIL b2b_divider: got div=%h cfg=%b expected 000007/1", divider, cfg_update_pulse);
    end
    put(8'h02);
    checks++;
    if ({meta_req_pulse, cfg_update_pulse} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_meta: got meta=%b cfg=%b expected 1/0", meta_req_pulse, cfg_update_pulse);
    end
    gap(); gap();
    checks++;
    if ({n_cfg - c0, read_count} !== {32'd1, 16'h1234}) begin
      errors++;
      $display("FAIL unknown_regs_kept: got cfgs=%0d rc=%h expected 1/1234", n_cfg - c0, read_count);
    end
  endtask

  task automatic test_reset_mid();
    put(8'h80); put(8'h11); put(8'h22);
    rx_valid = 1'b0;
    #2;
    ext_reset_n = 1'b0;
    #1;
    checks++;
    if ({divider, read_count, delay_count, trig_level_mask, trig_level_value,
         trig_fall_mask, trig_rise_mask} !== '0) begin
      errors++;
      $display("FAIL async_reset_cfg: got div=%h rc=%h dc=%h lvl=%h expected zero",
               divider, read_count, delay_count, trig_level_value);
    end
    @(negedge system_clock);
    ext_reset_n = 1'b1;
    @(negedge system_clock);
    put(8'h80); put(8'h00); put(8'h00); put(8'h00); put(8'h05);
    checks++;
    if ({divider, cfg_update_pulse} !== {24'h000005, 1'b1}) begin
      errors++;
      $display("FAIL fresh_after_reset: got div=%h cfg=%b expected 000005/1", divider, cfg_update_pulse);
    end
    gap();
  endtask

  initial begin
    test_reset();
    test_divider();
    test_cnt_trig();
    test_short();
    test_busy_long();
    test_timeout();
    test_timeout_edge();
    test_unknown_b2b();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
- Parses the SUMP byte stream from the UART receiver into short (1-byte) and long (5-byte) commands.
- Drives the capture configuration registers (divider, read/delay counts, trigger masks) and issues single-cycle control requests (reset, arm, ID query, metadata query) to the capture core and TX responder.
- Sits between the UART RX deserializer and the sampler/trigger/metadata blocks inside ACSP_top.
- An inter-byte timeout resynchronises the parser after a truncated long command.

Parameters:
- SAMPLE_WIDTH, 8, probe count; legal range 1..8.
- BYTE_TIMEOUT_CYCLES, 100000, system_clock cycles allowed between long-command bytes. The default is 1 ms at 100 MHz; one byte at 115200 baud is about 8680 cycles.

Ports:
- system_clock  in  1  sole clock, rising edge
- ext_reset_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data valid
- busy  in  1  capture armed/running or readout in progress
- soft_reset_pulse  out  1  opcode 0x00 received
- arm_pulse  out  1  opcode 0x01 accepted
- meta_req_pulse  out  1  opcode 0x02 accepted
- id_req_pulse  out  1  opcode 0x04 accepted
- divider  out  24  sample-rate divider
- read_count  out  16  samples to read
- delay_count  out  16  samples after trigger
- trig_level_mask  out  SAMPLE_WIDTH  level-trigger enable mask
- trig_level_value  out  SAMPLE_WIDTH  level-trigger compare value
- trig_fall_mask  out  SAMPLE_WIDTH  falling-edge trigger enables
- trig_rise_mask  out  SAMPLE_WIDTH  rising-edge trigger enables
- cfg_update_pulse  out  1  any config register written this cycle
- cmd_timeout_pulse  out  1  partial long command discarded

Behaviour:
- **Reset.** On ext_reset_n low, all outputs clear to 0 asynchronously and the FSM goes to IDLE.
- **FSM states.**
  - IDLE: waiting for an opcode.
  - ARGS: collecting 4 argument bytes; arg_cnt counts 0..3.
- **IDLE transitions.**
  - rx_valid with rx_data[7]=0 is a short command, executed and the FSM stays in IDLE.
  - rx_valid with rx_data[7]=1 latches the opcode, clears arg_cnt and the timer, and moves to ARGS.
- **ARGS.**
  - Each rx_valid stores the byte as b1..b4 in arrival order, increments arg_cnt and restarts the timer.
  - On b4 the command executes and the FSM returns to IDLE.
- **Busy sampling.** busy is sampled on the opcode byte's rx_valid cycle. That sample governs the whole command.
- **Latency.** All pulses and register updates appear on the clock edge following the rx_valid of the final byte. Pulses are exactly 1 cycle wide.
- **Short commands.**
  - 0x00: soft_reset_pulse, always, regardless of busy. Config registers are NOT cleared.
  - 0x01: arm_pulse, only if busy=0.
  - 0x02: meta_req_pulse, only if busy=0.
  - 0x04: id_req_pulse, only if busy=0.
  - Other 0x03..0x7F: ignored, no pulse.
- **Long commands.** Bytes are big-endian; b1 arrives first.
  - 0x80: divider = {b2,b3,b4}; b1 ignored.
  - 0x81: read_count = {b1,b2}; delay_count = {b3,b4}.
  - 0xC0: trig_level_value = b3[SAMPLE_WIDTH-1:0]; trig_level_mask = b4[SAMPLE_WIDTH-1:0].
  - 0xC1: trig_fall_mask = b3[SAMPLE_WIDTH-1:0]; trig_rise_mask = b4[SAMPLE_WIDTH-1:0]; b1 and b2 ignored.
  - Other 0x80..0xFF: all 4 argument bytes are consumed and discarded; no update.
- **cfg_update_pulse.** Asserted only when a known long command writes its registers.
- **Busy during long commands.** If busy=1 at the opcode, all 4 arguments are still consumed, but the register write and cfg_update_pulse are suppressed.
- **Timeout.**
  - In ARGS, the timer counts every cycle without rx_valid.
  - At BYTE_TIMEOUT_CYCLES-1 the FSM goes to IDLE, cmd_timeout_pulse asserts, and the partial arguments are dropped.
  - If rx_valid coincides with the expiry cycle, the byte wins: it is taken as an argument and there is no timeout.
  - A byte arriving after a timeout is parsed as an opcode.
- **Back-to-back bytes.** rx_valid on consecutive cycles must be handled without loss; there is no internal buffering beyond the argument registers.
- **Reset mid-command.** Asserting ext_reset_n mid-ARGS discards the partial command and clears all config registers.
- **Timer width.** The timer is $clog2(BYTE_TIMEOUT_CYCLES) bits and saturates; it never wraps.

Decomposition:
- **Package sump_pkg:**
  - opcode localparams: OP_RESET=8'h00, OP_ARM=8'h01, OP_META=8'h02, OP_ID=8'h04, OP_DIV=8'h80, OP_CNT=8'h81, OP_TRIG_LVL=8'hC0, OP_TRIG_EDGE=8'hC1;
  - FSM state enum {IDLE, ARGS};
  - LONG_ARG_BYTES=4.
- **Sub-module sump_byte_timer:**
  - the restartable, saturating inter-byte counter;
  - inputs: clear, enable;
  - output: expire.

Test Plan:
- **Divider.** Reset, then bytes 80 00 98 96 7F with busy=0 -> divider=24'h98967F and one cfg_update_pulse 1 cycle after the last rx_valid; no other register changes.
- **Read/delay and edge trigger.** 81 00 03 00 03, then C1 00 00 00 01 -> read_count=3, delay_count=3, trig_fall_mask=8'h00, trig_rise_mask=8'h01, two cfg_update_pulses.
- **Short commands and busy gating.**
  - 01, 02, 04 with busy=0 -> arm/meta/id pulses, each exactly 1 cycle.
  - The same bytes with busy=1 -> no pulses.
  - 00 with busy=1 -> soft_reset_pulse.
- **Busy during long command.** busy=1 during 80 00 00 01 F3 -> divider unchanged, no cfg_update_pulse; FSM back in IDLE, so a following 01 with busy=0 yields arm_pulse.
- **Timeout.**
  - 81 12 34, then silence for BYTE_TIMEOUT_CYCLES -> cmd_timeout_pulse once, read_count unchanged; a following 00 gives soft_reset_pulse.
  - Repeat with a byte landing exactly on the expiry cycle -> accepted as an argument, no timeout.
- **Unknown opcodes and reset mid-command.**
  - Unknown long opcode 9A followed by 4 bytes, then 01 -> no update, arm_pulse.
  - Assert ext_reset_n low mid-ARGS -> all outputs 0 asynchronously; the next byte 80 starts a fresh command.
